cu_fsm: RTL

CU_FSM -- requirements
Module: cu_fsm

---
 rtl/otter_pkg.sv | 35 +++
 rtl/instret_counter.sv | 21 ++
 rtl/cu_fsm.sv | 110 +++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER control definitions: FSM state encoding and RV32I major opcodes.
// Used by both the control unit and the decoder.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYS    = 7'b1110011;

  localparam logic [2:0] F3_MRET   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;

  // Opcodes that retire in EXEC by writing a result into the register file.
  function automatic logic isRegWriteOp(input logic [6:0] opcode);
    return (opcode == OP) || (opcode == OP_IMM) || (opcode == LUI) ||
           (opcode == AUIPC) || (opcode == JAL) || (opcode == JALR);
  endfunction

endpackage

// File: rtl/instret_counter.sv
// 32-bit retired-instruction counter; wraps naturally, synchronous clear
// has priority over increment.
module instret_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (inc)
      r_count <= r_count + 32'd1;
  end

  assign count = r_count;

endmodule

// File: rtl/cu_fsm.sv
// OTTER multicycle control unit: sequences fetch/execute/writeback and
// interrupt entry, and counts retired instructions.
module cu_fsm
  import otter_pkg::*;
(
  input  logic        FSM_clk,
  input  logic        FSM_rst,
  input  logic [6:0]  FSM_ir_opcode,
  input  logic [2:0]  FSM_ir_funct,
  input  logic        FSM_intr,
  output logic        FSM_pc_write,
  output logic        FSM_reg_write,
  output logic        FSM_mem_rden1,
  output logic        FSM_mem_rden2,
  output logic        FSM_mem_we2,
  output logic        FSM_csr_we,
  output logic        FSM_int_taken,
  output logic        FSM_mret_exec,
  output logic        FSM_reset,
  output logic [31:0] FSM_instret,
  output logic [2:0]  FSM_state
);

  state_t r_state;
  state_t w_nextState;
  logic   w_inc;

  always_ff @(posedge FSM_clk) begin
    if (FSM_rst)
      r_state <= ST_INIT;
    else
      r_state <= w_nextState;
  end

  // The interrupt line is only looked at on the edge that retires an instruction.
  always_comb begin
    FSM_pc_write  = 1'b0;
    FSM_reg_write = 1'b0;
    FSM_mem_rden1 = 1'b0;
    FSM_mem_rden2 = 1'b0;
    FSM_mem_we2   = 1'b0;
    FSM_csr_we    = 1'b0;
    FSM_int_taken = 1'b0;
    FSM_mret_exec = 1'b0;
    FSM_reset     = 1'b0;
    w_nextState   = ST_INIT;

    case (r_state)
      ST_INIT: begin
        FSM_reset   = 1'b1;
        w_nextState = ST_FETCH;
      end

      ST_FETCH: begin
        FSM_mem_rden1 = 1'b1;
        w_nextState   = ST_EXEC;
      end

      ST_EXEC: begin
        if (FSM_ir_opcode == LOAD) begin
          FSM_mem_rden2 = 1'b1;
          w_nextState   = ST_WB;
        end else begin
          FSM_pc_write = 1'b1;
          w_nextState  = FSM_intr ? ST_INTR : ST_FETCH;
          if (FSM_ir_opcode == STORE) begin
            FSM_mem_we2 = 1'b1;
          end else if (isRegWriteOp(FSM_ir_opcode)) begin
            FSM_reg_write = 1'b1;
          end else if (FSM_ir_opcode == SYS) begin
            if (FSM_ir_funct == F3_MRET) begin
              FSM_mret_exec = 1'b1;
            end else if ((FSM_ir_funct == F3_CSRRW) || (FSM_ir_funct == F3_CSRRS) ||
                         (FSM_ir_funct == F3_CSRRC)) begin
              FSM_csr_we    = 1'b1;
              FSM_reg_write = 1'b1;
            end
          end
        end
      end

      ST_WB: begin
        FSM_reg_write = 1'b1;
        FSM_pc_write  = 1'b1;
        w_nextState   = FSM_intr ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        FSM_int_taken = 1'b1;
        FSM_pc_write  = 1'b1;
        w_nextState   = ST_FETCH;
      end

      default: w_nextState = ST_INIT;
    endcase
  end

  // The PC load in INTR redirects to the handler and retires nothing.
  assign w_inc = FSM_pc_write && (r_state != ST_INTR);

  instret_counter uInstret (
    .clk   (FSM_clk),
    .rst   (FSM_rst),
    .inc   (w_inc),
    .count (FSM_instret)
  );

  assign FSM_state = r_state;

endmodule
